// File: rtl/s2b_pkg.sv
// Shared types and helpers for the stochastic-to-binary converter.
// The top level is built single-shot by default; defining S2B_CONTINUOUS_EN
// enables back-to-back windows and the sticky overrun output.
package s2b_pkg;

    typedef enum logic [1:0] {
        S2B_IDLE,
        S2B_ACCUM,
        S2B_HOLD
    } s2b_state_t;

    localparam int S2B_OUT_W           = 8;
    localparam int S2B_WINDOW_LOG2_MIN = 8;
    localparam int S2B_WINDOW_LOG2_MAX = 16;

    // Map a ones-count over a 2^w window onto 0..255: a full window saturates
    // to all-ones, otherwise the top eight bits of the w-bit count (truncated).
    function automatic logic [S2B_OUT_W-1:0] s2b_scale(
        input logic [S2B_WINDOW_LOG2_MAX:0] ones,
        input int unsigned                  w
    );
        logic [S2B_WINDOW_LOG2_MAX:0] full;
        logic [S2B_WINDOW_LOG2_MAX:0] shifted;
        full    = {{S2B_WINDOW_LOG2_MAX{1'b0}}, 1'b1} << w;
        shifted = ones >> (w - S2B_OUT_W);
        if (ones == full) begin
            return '1;
        end
        return shifted[S2B_OUT_W-1:0];
    endfunction

endpackage

// File: rtl/s2b_window_counter.sv
// Sample and ones counters for one conversion window. ones_next is the count
// including the sample currently presented, so the top level can capture the
// final total on the same edge that takes the last sample.
module s2b_window_counter
    import s2b_pkg::*;
#(
    parameter int WINDOW_LOG2 = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 bit_in,
    output logic [WINDOW_LOG2:0] ones_next,
    output logic                 window_done
);

    logic [WINDOW_LOG2-1:0] sample_cnt;
    logic [WINDOW_LOG2:0]   ones_cnt;

    assign ones_next   = ones_cnt + {{WINDOW_LOG2{1'b0}}, bit_in};
    // The 2^W-th sample is the one taken while sample_cnt is all ones.
    assign window_done = enable && (sample_cnt == '1);

    // Count valid samples and ones; clear has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            ones_cnt   <= '0;
        end else if (clear) begin
            sample_cnt <= '0;
            ones_cnt   <= '0;
        end else if (enable) begin
            sample_cnt <= sample_cnt + 1'b1;
            ones_cnt   <= ones_next;
        end
    end

endmodule

// File: rtl/stochastic_to_binary_converter.sv
// Decodes a unipolar stochastic bitstream into an 8-bit value by counting ones
// over 2^WINDOW_LOG2 valid samples; result leaves on a valid/ready handshake.
// Optional feature macro: S2B_CONTINUOUS_EN (back-to-back windows, overrun flag).
module stochastic_to_binary_converter
    import s2b_pkg::*;
#(
    parameter int WINDOW_LOG2 = 8,
    parameter int OUT_W       = S2B_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             busy,
    output logic [OUT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready
`ifdef S2B_CONTINUOUS_EN
    ,
    output logic             overrun
`endif
);

    s2b_state_t                   state;
    logic                         cnt_clear;
    logic                         cnt_enable;
    logic [WINDOW_LOG2:0]         ones_next;
    logic                         window_done;
    logic [S2B_WINDOW_LOG2_MAX:0] ones_ext;
    logic [S2B_OUT_W-1:0]         scaled;

    assign cnt_enable = (state == S2B_ACCUM) && bit_valid;

    // Counters clear when a window opens, on abort, and (continuous) on each completion.
    always_comb begin
        cnt_clear = abort || ((state == S2B_IDLE) && start);
`ifdef S2B_CONTINUOUS_EN
        if (window_done) begin
            cnt_clear = 1'b1;
        end
`endif
    end

    // Widen the final count to the package helper's fixed input width.
    always_comb begin
        ones_ext                = '0;
        ones_ext[WINDOW_LOG2:0] = ones_next;
    end

    assign scaled = s2b_scale(ones_ext, WINDOW_LOG2);

    s2b_window_counter #(
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_window_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (cnt_clear),
        .enable      (cnt_enable),
        .bit_in      (bit_in),
        .ones_next   (ones_next),
        .window_done (window_done)
    );

    // Control FSM with registered busy/result/handshake outputs; abort dominates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S2B_IDLE;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
`ifdef S2B_CONTINUOUS_EN
            overrun      <= 1'b0;
`endif
        end else if (abort) begin
            state        <= S2B_IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
`ifdef S2B_CONTINUOUS_EN
            overrun      <= 1'b0;
`endif
        end else begin
            case (state)
                S2B_IDLE: begin
                    if (start) begin
                        state <= S2B_ACCUM;
                        busy  <= 1'b1;
                    end
                end
`ifdef S2B_CONTINUOUS_EN
                S2B_ACCUM: begin
                    // The output register drains independently of the stream.
                    if (result_valid && result_ready) begin
                        result_valid <= 1'b0;
                    end
                    if (window_done) begin
                        result       <= scaled[OUT_W-1:0];
                        result_valid <= 1'b1;
                        if (result_valid && !result_ready) begin
                            overrun <= 1'b1;
                        end
                    end
                end
`else
                S2B_ACCUM: begin
                    if (window_done) begin
                        state        <= S2B_HOLD;
                        busy         <= 1'b0;
                        result       <= scaled[OUT_W-1:0];
                        result_valid <= 1'b1;
                    end
                end
`endif
                S2B_HOLD: begin
                    if (result_ready) begin
                        state        <= S2B_IDLE;
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= S2B_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stochastic_to_binary_converter.sv
// Directed-plus-random bench for the single-shot converter (W = 8).
module tb_stochastic_to_binary_converter;

    localparam int W     = 8;
    localparam int NWIN  = 1 << W;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       bit_in;
    logic       bit_valid;
    logic       busy;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ready;
`ifdef S2B_CONTINUOUS_EN
    logic       overrun;
`endif

    int errors = 0;
    int checks = 0;

    stochastic_to_binary_converter #(
        .WINDOW_LOG2 (W),
        .OUT_W       (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
`ifdef S2B_CONTINUOUS_EN
        ,
        .overrun      (overrun)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: fraction of ones over the window expressed on 0..255.
    function automatic logic [7:0] model(input int ones);
        if (ones >= NWIN) return 8'hFF;
        return 8'((ones * 256) / NWIN);
    endfunction

    // Bit pattern source: 0 zeros, 1 ones, 2 one every 4th sample, 3 random.
    function automatic logic gen(input int mode, input int idx);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (idx % 4) == 0;
            default: return 1'($urandom_range(1));
        endcase
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Feed n valid samples; reports ones taken, elapsed cycles, and whether
    // result_valid showed up before the final sample.
    task automatic feed(input int n, input int mode, input int vpct,
                        output int ones, output int cycles, output bit early);
        int taken;
        logic v;
        taken  = 0;
        ones   = 0;
        cycles = 0;
        early  = 1'b0;
        while (taken < n && cycles < 20000) begin
            v = ($urandom_range(99) < vpct);
            bit_valid = v;
            bit_in    = gen(mode, taken);
            if (v) begin
                taken++;
                ones += int'(bit_in);
            end
            tick();
            cycles++;
            if (taken < n && result_valid) early = 1'b1;
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        check("feed_budget", taken, n);
    endtask

    initial begin
        int   ones;
        int   cyc;
        bit   early;
        bit   stable;
        logic [7:0] held;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        bit_in = 1'b0; bit_valid = 1'b0; result_ready = 1'b0;
        #12;
        check("reset_busy", busy, 0);
        check("reset_result", result, 0);
        check("reset_valid", result_valid, 0);
        rst_n = 1'b1;
        tick();

        // All ones, every cycle valid -> saturates
        pulse_start();
        check("t1_busy", busy, 1);
        feed(NWIN, 1, 100, ones, cyc, early);
        check("t1_early", early, 0);
        check("t1_valid", result_valid, 1);
        check("t1_result", result, 8'hFF);
        check("t1_busy_low", busy, 0);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("t1_valid_drop", result_valid, 0);
        check("t1_result_kept", result, 8'hFF);

        // All zeros
        pulse_start();
        feed(NWIN, 0, 100, ones, cyc, early);
        check("t2_zero", result, 8'h00);
        check("t2_zero_valid", result_valid, 1);
        result_ready = 1'b1; tick(); result_ready = 1'b0;

        // One every fourth sample -> quarter scale
        pulse_start();
        feed(NWIN, 2, 100, ones, cyc, early);
        check("t2_quarter", result, 8'h40);
        check("t2_quarter_model", result, model(ones));
        result_ready = 1'b1; tick(); result_ready = 1'b0;

        // Stalled stream of ones -> window stretches, still saturates
        pulse_start();
        feed(NWIN, 1, 50, ones, cyc, early);
        check("t4_long_busy", cyc > NWIN, 1);
        check("t4_early", early, 0);
        check("t4_result", result, 8'hFF);
        result_ready = 1'b1; tick(); result_ready = 1'b0;

        // Random streams with random stalls vs. model
        for (int k = 0; k < 3; k++) begin
            pulse_start();
            feed(NWIN, 3, 70, ones, cyc, early);
            check("rand_valid", result_valid, 1);
            check("rand_result", result, model(ones));
            result_ready = 1'b1; tick(); result_ready = 1'b0;
        end

        // Back-pressure in HOLD: stable output, start ignored
        pulse_start();
        feed(NWIN, 3, 100, ones, cyc, early);
        held   = result;
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            start = (k % 3 == 0);
            tick();
            if (result !== held || result_valid !== 1'b1 || busy !== 1'b0) stable = 1'b0;
        end
        start = 1'b0;
        check("t5_stable", stable, 1);
        check("t5_result", held, model(ones));
        result_ready = 1'b1; tick(); result_ready = 1'b0;
        check("t5_valid_drop", result_valid, 0);
        check("t5_idle_busy", busy, 0);
        pulse_start();
        check("t5_idle_accepts_start", busy, 1);

        // Reset in mid-window
        feed(100, 1, 100, ones, cyc, early);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_valid", result_valid, 0);
        check("t6_rst_result", result, 0);
        #3;
        rst_n = 1'b1;
        tick();
        pulse_start();
        feed(NWIN, 3, 80, ones, cyc, early);
        check("t6_rst_recover", result, model(ones));
        result_ready = 1'b1; tick(); result_ready = 1'b0;

        // Abort in mid-window
        pulse_start();
        feed(100, 1, 100, ones, cyc, early);
        abort = 1'b1; tick(); abort = 1'b0;
        check("t6_abort_busy", busy, 0);
        check("t6_abort_valid", result_valid, 0);
        pulse_start();
        feed(NWIN, 2, 100, ones, cyc, early);
        check("t6_abort_recover", result, 8'h40);

        // Abort in HOLD discards the pending result
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_hold_valid", result_valid, 0);

        // Abort beats a simultaneous start in IDLE
        start = 1'b1; abort = 1'b1; tick();
        start = 1'b0; abort = 1'b0;
        check("abort_over_start", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
